// File: rtl/wb_arbiter_if.sv
// Execution-unit completion inputs and the single writeback channel
// toward the reorder buffer, grouped as one bundle.
interface wb_arbiter_if #(
    parameter int DATA      = 32,
    parameter int ROB_DEPTH = 16,
    parameter int EXP       = 4,
    parameter int NUM_UNITS = 3
);
    localparam int ROB = $clog2(ROB_DEPTH);

    logic [NUM_UNITS-1:0]      unit_e_;
    logic [NUM_UNITS-1:0]      unit_ready;
    logic [NUM_UNITS*ROB-1:0]  unit_rob_id;
    logic [NUM_UNITS*DATA-1:0] unit_data;
    logic [NUM_UNITS-1:0]      unit_exp_;
    logic [NUM_UNITS*EXP-1:0]  unit_exp_code;
    logic [NUM_UNITS-1:0]      unit_pred_miss_;
    logic [NUM_UNITS-1:0]      unit_jump_miss_;

    logic                      wb_e_;
    logic [ROB-1:0]            wb_rob_id;
    logic [DATA-1:0]           wb_data;
    logic                      wb_exp_;
    logic [EXP-1:0]            wb_exp_code;
    logic                      wb_pred_miss_;
    logic                      wb_jump_miss_;
    logic                      wb_pending;

    modport slave (
        input  unit_e_, unit_rob_id, unit_data, unit_exp_,
        input  unit_exp_code, unit_pred_miss_, unit_jump_miss_,
        output unit_ready,
        output wb_e_, wb_rob_id, wb_data, wb_exp_, wb_exp_code,
        output wb_pred_miss_, wb_jump_miss_, wb_pending
    );

    modport master (
        output unit_e_, unit_rob_id, unit_data, unit_exp_,
        output unit_exp_code, unit_pred_miss_, unit_jump_miss_,
        input  unit_ready,
        input  wb_e_, wb_rob_id, wb_data, wb_exp_, wb_exp_code,
        input  wb_pred_miss_, wb_jump_miss_, wb_pending
    );
endinterface

// File: rtl/wb_arbiter.sv
// Per-unit result FIFOs merged round-robin into one registered
// writeback per cycle toward the reorder buffer.
module wb_arbiter #(
    parameter int DATA       = 32,
    parameter int ROB_DEPTH  = 16,
    parameter int EXP        = 4,
    parameter int NUM_UNITS  = 3,
    parameter int FIFO_DEPTH = 2
) (
    input logic         clk,
    input logic         reset,
    input logic         flush_,
    wb_arbiter_if.slave bus
);
    localparam int ROB = $clog2(ROB_DEPTH);
    localparam int PTR = $clog2(FIFO_DEPTH);
    localparam int CNT = PTR + 1;
    localparam int RRW = $clog2(NUM_UNITS);
    localparam int PW  = ROB + DATA + EXP + 3;

    typedef logic [PW-1:0] pay_t;

    // Payload layout: {rob_id, data, exp_code, exp_, pred_miss_, jump_miss_}
    localparam pay_t RST_PAY = pay_t'(3'b111);

    pay_t                 mem_q [NUM_UNITS][FIFO_DEPTH];
    pay_t                 mem_d [NUM_UNITS][FIFO_DEPTH];
    logic [PTR-1:0]       wp_q  [NUM_UNITS];
    logic [PTR-1:0]       wp_d  [NUM_UNITS];
    logic [PTR-1:0]       rp_q  [NUM_UNITS];
    logic [PTR-1:0]       rp_d  [NUM_UNITS];
    logic [CNT-1:0]       cnt_q [NUM_UNITS];
    logic [CNT-1:0]       cnt_d [NUM_UNITS];
    logic [RRW-1:0]       rr_q, rr_d;
    logic                 wb_e_q, wb_e_d;
    pay_t                 wb_pay_q, wb_pay_d;
    logic                 pend_q, pend_d;

    logic [NUM_UNITS-1:0] rdy, push, pop;
    logic                 found;
    logic [RRW-1:0]       gidx;
    pay_t                 head;
    int                   j;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            rdy[i]  = !reset && (cnt_q[i] != CNT'(FIFO_DEPTH));
            push[i] = !bus.unit_e_[i] && rdy[i];
        end
    end

    // Round-robin search starting at rr_q, wrapping modulo NUM_UNITS
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_UNITS) j = j - NUM_UNITS;
            if (!found && cnt_q[j] != '0) begin
                found = 1'b1;
                gidx  = RRW'(j);
            end
        end
        head = mem_q[gidx][rp_q[gidx]];
        for (int i = 0; i < NUM_UNITS; i++)
            pop[i] = found && (gidx == RRW'(i));
    end

    always_comb begin
        mem_d    = mem_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        wb_e_d   = 1'b1;
        wb_pay_d = wb_pay_q;
        pend_d   = 1'b0;
        if (!flush_) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                wp_d[i]  = '0;
                rp_d[i]  = '0;
                cnt_d[i] = '0;
            end
            rr_d = '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (push[i]) begin
                    mem_d[i][wp_q[i]] = {
                        bus.unit_rob_id[i*ROB +: ROB],
                        bus.unit_data[i*DATA +: DATA],
                        bus.unit_exp_code[i*EXP +: EXP],
                        bus.unit_exp_[i],
                        bus.unit_pred_miss_[i],
                        bus.unit_jump_miss_[i]};
                    wp_d[i] = wp_q[i] + PTR'(1);
                end
                if (pop[i]) rp_d[i] = rp_q[i] + PTR'(1);
                cnt_d[i] = cnt_q[i] + CNT'(push[i]) - CNT'(pop[i]);
            end
            if (found) begin
                rr_d     = (gidx == RRW'(NUM_UNITS - 1)) ? '0 : gidx + RRW'(1);
                wb_e_d   = 1'b0;
                wb_pay_d = head;
            end
        end
        for (int i = 0; i < NUM_UNITS; i++)
            if (cnt_d[i] != '0) pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            rr_q     <= '0;
            wb_e_q   <= 1'b1;
            wb_pay_q <= RST_PAY;
            pend_q   <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            wb_e_q   <= wb_e_d;
            wb_pay_q <= wb_pay_d;
            pend_q   <= pend_d;
        end
    end

    // Storage needs no reset: counts gate every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.unit_ready = rdy;
    assign bus.wb_e_      = wb_e_q;
    assign bus.wb_pending = pend_q;
    assign {bus.wb_rob_id, bus.wb_data, bus.wb_exp_code,
            bus.wb_exp_, bus.wb_pred_miss_, bus.wb_jump_miss_} = wb_pay_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table plus hand sequences for the writeback arbiter:
// contention, fairness, back-pressure, flush, exceptions, reset.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic flush_;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .flush_ (flush_),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0] ue;
        logic [3:0] r0, r1, r2;
        logic       e;
        logic [3:0] rid;
        int         unit;
        logic       pend;
        logic [2:0] rdy;
    } vec_t;

    vec_t vecs [12];

    always @(posedge clk)
        if (!reset)
            assert ((~bus.unit_e_ & ~bus.unit_ready) == 3'b000)
            else $error("push issued to a unit whose fifo is full");

    function automatic logic [31:0] dat(input int u, input logic [3:0] r);
        return {16'hCAFE, 4'(u), 4'h0, r, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ue, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c);
        bus.unit_e_         = ue;
        bus.unit_rob_id     = {c, b, a};
        bus.unit_data       = {dat(2, c), dat(1, b), dat(0, a)};
        bus.unit_exp_       = 3'b111;
        bus.unit_exp_code   = '0;
        bus.unit_pred_miss_ = 3'b111;
        bus.unit_jump_miss_ = 3'b111;
    endtask

    task automatic chk_wb(input string nm, input logic e,
                          input logic [3:0] rid, input logic [31:0] d,
                          input logic pend);
        chk({nm, "_e"},    32'(bus.wb_e_), 32'(e));
        chk({nm, "_rid"},  32'(bus.wb_rob_id), 32'(rid));
        chk({nm, "_data"}, bus.wb_data, d);
        chk({nm, "_pend"}, 32'(bus.wb_pending), 32'(pend));
    endtask

    initial begin
        //          ue      r0 r1 r2   e  rid unit pend rdy
        vecs[0]  = '{3'b111, 0, 0, 0, 1, 0, -1, 0, 3'b111};
        vecs[1]  = '{3'b000, 1, 2, 3, 1, 0, -1, 0, 3'b111};
        vecs[2]  = '{3'b111, 0, 0, 0, 1, 0, -1, 1, 3'b111};
        vecs[3]  = '{3'b111, 0, 0, 0, 0, 1,  0, 1, 3'b111};
        vecs[4]  = '{3'b111, 0, 0, 0, 0, 2,  1, 1, 3'b111};
        vecs[5]  = '{3'b111, 0, 0, 0, 0, 3,  2, 0, 3'b111};
        vecs[6]  = '{3'b110, 4, 0, 0, 1, 3,  2, 0, 3'b111};
        vecs[7]  = '{3'b010, 5, 0, 9, 1, 3,  2, 1, 3'b111};
        vecs[8]  = '{3'b110, 6, 0, 0, 0, 4,  0, 1, 3'b111};
        vecs[9]  = '{3'b111, 0, 0, 0, 0, 9,  2, 1, 3'b110};
        vecs[10] = '{3'b111, 0, 0, 0, 0, 5,  0, 1, 3'b111};
        vecs[11] = '{3'b111, 0, 0, 0, 0, 6,  0, 0, 3'b111};

        reset  = 1'b1;
        flush_ = 1'b1;
        drive(3'b111, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.unit_ready), 32'h0);
        chk("rst_flags", {29'h0, bus.wb_exp_, bus.wb_pred_miss_,
                          bus.wb_jump_miss_}, 32'h7);
        chk("rst_code", 32'(bus.wb_exp_code), 32'h0);
        reset = 1'b0;

        // Contention, round-robin fairness and back-pressure
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk_wb($sformatf("vec%0d", i), vecs[i].e, vecs[i].rid,
                   (vecs[i].unit < 0) ? 32'h0 : dat(vecs[i].unit, vecs[i].rid),
                   vecs[i].pend);
            chk($sformatf("vec%0d_rdy", i), 32'(bus.unit_ready),
                32'(vecs[i].rdy));
            drive(vecs[i].ue, vecs[i].r0, vecs[i].r1, vecs[i].r2);
        end

        // Flush with results buffered and a same-cycle push
        @(negedge clk);
        drive(3'b000, 1, 2, 3);
        @(negedge clk);
        drive(3'b110, 4, 0, 0);
        @(negedge clk);
        chk_wb("flush_pre", 1'b0, 2, dat(1, 2), 1'b1);
        flush_ = 1'b0;
        drive(3'b101, 0, 7, 0);
        @(negedge clk);
        flush_ = 1'b1;
        drive(3'b111, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush_idle%0d_e", i), 32'(bus.wb_e_), 32'h1);
            chk($sformatf("flush_idle%0d_pend", i), 32'(bus.wb_pending), 32'h0);
            @(negedge clk);
        end
        drive(3'b110, 8, 0, 0);
        @(negedge clk);
        drive(3'b111, 0, 0, 0);
        chk("flush_t1_e", 32'(bus.wb_e_), 32'h1);
        chk("flush_t1_pend", 32'(bus.wb_pending), 32'h1);
        @(negedge clk);
        chk_wb("flush_t2", 1'b0, 8, dat(0, 8), 1'b0);
        @(negedge clk);
        chk("flush_t3_e", 32'(bus.wb_e_), 32'h1);

        // Exception and mispredict flags pass through
        drive(3'b011, 0, 0, 4'hA);
        bus.unit_exp_       = 3'b011;
        bus.unit_exp_code   = {4'h2, 4'h0, 4'h0};
        bus.unit_pred_miss_ = 3'b011;
        @(negedge clk);
        drive(3'b111, 0, 0, 0);
        chk("exc_t1_e", 32'(bus.wb_e_), 32'h1);
        @(negedge clk);
        chk_wb("exc_t2", 1'b0, 4'hA, dat(2, 4'hA), 1'b0);
        chk("exc_exp", 32'(bus.wb_exp_), 32'h0);
        chk("exc_code", 32'(bus.wb_exp_code), 32'h2);
        chk("exc_pred", 32'(bus.wb_pred_miss_), 32'h0);
        chk("exc_jump", 32'(bus.wb_jump_miss_), 32'h1);

        // Reset mid-stream discards buffered results
        drive(3'b100, 3, 4, 0);
        @(negedge clk);
        drive(3'b111, 0, 0, 0);
        chk("mid_pend", 32'(bus.wb_pending), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.unit_ready), 32'h0);
        chk_wb("mid_rst", 1'b1, 0, 32'h0, 1'b0);
        chk("mid_rst_flags", {29'h0, bus.wb_exp_, bus.wb_pred_miss_,
                              bus.wb_jump_miss_}, 32'h7);
        chk("mid_rst_code", 32'(bus.wb_exp_code), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_idle%0d_e", i), 32'(bus.wb_e_), 32'h1);
        end

        // Single result, two-cycle latency
        drive(3'b101, 0, 5, 0);
        bus.unit_data[63:32] = 32'hDEADBEEF;
        @(negedge clk);
        drive(3'b111, 0, 0, 0);
        chk("single_t1_e", 32'(bus.wb_e_), 32'h1);
        @(negedge clk);
        chk_wb("single_t2", 1'b0, 5, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk_wb("single_t3", 1'b1, 5, 32'hDEADBEEF, 1'b0);
        chk("single_t3_rdy", 32'(bus.unit_ready), 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
